// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side drain stage for a synchronous FIFO with one cycle of read
//   latency. Issues FIFO reads, parks returning words in a two-entry skid
//   buffer, and presents them as a valid/ready stream framed into packets
//   of PKT_LEN beats.
//
// Ports
//   clk, rst     : single clock, asynchronous active-high reset
//   en           : 1 = fetch from FIFO, 0 = stop fetching and drain
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : FIFO read strobe
//   fifo_rdata   : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid      : output beat valid
//   m_ready      : sink accepts beat
//   m_data       : output beat data
//   m_last       : final beat of a packet
//   pkt_cnt      : completed packet count, wraps
//   idle         : FSM is in IDLE
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             idle
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;
    logic [IDX_W-1:0] beat_idx;
    logic             pop;
    logic [2:0]       pending;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = buf0;
    assign m_last  = m_valid && (beat_idx == LAST_IDX);
    assign idle    = (state == S_IDLE);

    // Words that will occupy the buffer after this edge, counting the one
    // in flight; a new read is only allowed if it will still find a slot.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_RUN;
            end
            S_RUN: begin
                fifo_rd_en = !fifo_empty && (pending < 3'd2);
                if (!en) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (en)                                 state_nxt = S_RUN;
                else if (occ == 2'd0 && !inflight)      state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
        end
    end

    // Skid buffer: buf0 is always the head. Capture and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= fifo_rdata;
                    else             buf1 <= fifo_rdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            if (m_last) begin
                beat_idx <= '0;
                pkt_cnt  <= pkt_cnt + 1'b1;
            end else begin
                beat_idx <= beat_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Drives fifo_stream_reader from a queue-backed FIFO with one cycle of
//   read latency and compares every cycle against a count-based model.
module tb_fifo_stream_reader;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [CNT_W-1:0] pkt_cnt;
    logic             idle;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH  (WIDTH),
        .PKT_LEN(PKT_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .pkt_cnt   (pkt_cnt),
        .idle      (idle)
    );

    int checks = 0;
    int errors = 0;

    // FIFO contents as seen by the DUT, and the model's own copy.
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] src_q[$];
    // Model: words that have landed in the buffer, in order.
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] pend;
    bit               infl_m;
    int               mode;      // 0 idle, 1 run, 2 drain
    int               beats;
    int               pkts;
    bit               last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        fifo_q.push_back(v);
        src_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: check at negedge, advance FIFO and model after posedge.
    task automatic cycle();
        int occ;
        bit pop, rd, last, old_infl, exp_valid;
        logic [WIDTH-1:0] exp_data;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        occ       = sb_q.size();
        exp_valid = (occ != 0);
        exp_data  = exp_valid ? sb_q[0] : '0;
        last      = exp_valid && ((beats % PKT_LEN) == PKT_LEN - 1);
        pop       = exp_valid && m_ready;
        rd        = (mode == 1) && !fifo_empty && ((occ + int'(infl_m) - int'(pop)) < 2);
        if (rst) begin
            check_eq("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
            check_eq("rst_m_valid",    32'(m_valid),    32'd0);
            check_eq("rst_m_last",     32'(m_last),     32'd0);
            check_eq("rst_m_data",     32'(m_data),     32'd0);
            check_eq("rst_idle",       32'(idle),       32'd1);
            check_eq("rst_pkt_cnt",    32'(pkt_cnt),    32'd0);
        end else begin
            check_eq("fifo_rd_en", 32'(fifo_rd_en), 32'(rd));
            check_eq("m_valid",    32'(m_valid),    32'(exp_valid));
            if (exp_valid) check_eq("m_data", 32'(m_data), 32'(exp_data));
            check_eq("m_last",     32'(m_last),     32'(last));
            check_eq("idle",       32'(idle),       32'(mode == 0));
            check_eq("pkt_cnt",    32'(pkt_cnt),    32'(pkts % (1 << CNT_W)));
        end
        last_rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (last_rd && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
        if (rst) begin
            sb_q.delete();
            infl_m = 1'b0;
            mode   = 0;
            beats  = 0;
            pkts   = 0;
        end else begin
            old_infl = infl_m;
            if (pop) begin
                void'(sb_q.pop_front());
                beats++;
                if (last) pkts++;
            end
            if (infl_m) sb_q.push_back(pend);
            if (rd && src_q.size() != 0) pend = src_q.pop_front();
            infl_m = rd;
            case (mode)
                0: if (en) mode = 1;
                1: if (!en) mode = 2;
                default: begin
                    if (en)                          mode = 1;
                    else if (occ == 0 && !old_infl)  mode = 0;
                end
            endcase
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        m_ready    = 1'b1;
        fifo_rdata = '0;
        fifo_empty = 1'b1;
        infl_m     = 1'b0;
        mode       = 0;
        beats      = 0;
        pkts       = 0;
        pend       = '0;
        last_rd    = 1'b0;

        // Reset held with en high and a non-empty FIFO.
        for (int v = 8'h10; v <= 8'h17; v++) push(8'(v));
        run(3);

        // Streaming of 0x10..0x17: two packets.
        rst = 1'b0;
        run(14);
        check_eq("pkt_cnt_after_stream", 32'(pkt_cnt), 32'd2);

        // Backpressure mid-stream.
        for (int v = 8'h20; v < 8'h28; v++) push(8'(v));
        run(3);
        m_ready = 1'b0;
        run(5);
        m_ready = 1'b1;
        run(10);

        // Underflow: three beats, FIFO runs dry, fourth beat closes the packet.
        for (int v = 8'h30; v < 8'h33; v++) push(8'(v));
        run(8);
        run(6);
        push(8'h33);
        run(5);
        check_eq("pkt_cnt_after_underflow", 32'(pkt_cnt), 32'd1);

        // Drain: drop en right after a read, wait for idle, then resume.
        for (int v = 8'h40; v < 8'h46; v++) push(8'(v));
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_rd) break;
        end
        en      = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (idle) break;
        end
        check_eq("idle_after_drain", 32'(idle), 32'd1);
        run(3);
        en = 1'b1;
        run(12);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 3) == 0 && fifo_q.size() < 16) push(8'($urandom));
            en      = (($urandom % 10) != 0);
            m_ready = (($urandom % 3) != 0);
            rst     = (($urandom % 250) == 0);
            cycle();
        end
        rst = 1'b0;
        en  = 1'b1;
        m_ready = 1'b1;
        run(40);
        check_eq("pkt_cnt_final", 32'(pkt_cnt), 32'(pkts % (1 << CNT_W)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
